// File: rtl/icache_fetch_if.sv
// Handshake bundle between the icache request queue, memory read port,
// line fill port and fetch response port of icache_fetch.
interface icache_fetch_if #(
   parameter int ADDRBITS = 32,
   parameter int DATABITS = 32
);
   logic [ADDRBITS-1:0] queue_out_addr;
   logic [1:0]          queue_out_wordlen;
   logic                queue_not_empty;
   logic                queue_pop;
   logic                flush;
   logic                mem_rd_req;
   logic [ADDRBITS-1:0] mem_addr;
   logic                mem_ack;
   logic                mem_rd_valid;
   logic [DATABITS-1:0] mem_rd_data;
   logic                fill_we;
   logic [ADDRBITS-1:0] fill_addr;
   logic [DATABITS-1:0] fill_data;
   logic                fill_done;
   logic                resp_valid;
   logic [DATABITS-1:0] resp_data;
   logic                busy;

   modport master (
      input  queue_out_addr, queue_out_wordlen, queue_not_empty, flush,
      input  mem_ack, mem_rd_valid, mem_rd_data,
      output queue_pop, mem_rd_req, mem_addr,
      output fill_we, fill_addr, fill_data, fill_done,
      output resp_valid, resp_data, busy
   );

   modport slave (
      output queue_out_addr, queue_out_wordlen, queue_not_empty, flush,
      output mem_ack, mem_rd_valid, mem_rd_data,
      input  queue_pop, mem_rd_req, mem_addr,
      input  fill_we, fill_addr, fill_data, fill_done,
      input  resp_valid, resp_data, busy
   );
endinterface

// File: rtl/icache_fetch.sv
// Line-fill engine: pulls the head request from the icache queue, issues one
// line burst read, writes every beat into the line and returns the critical word.
module icache_fetch #(
   parameter int DATABITS     = 32,
   parameter int ADDRBITS     = 32,
   parameter int LINEWORDBITS = 3,
   parameter int LINEWORDS    = 2**LINEWORDBITS
) (
   input logic            clk,
   input logic            reset_n,
   icache_fetch_if.master bus
);
   localparam int OFFBITS = LINEWORDBITS + 2;

   typedef enum logic [1:0] {IDLE, REQ, BURST, DONE} state_t;

   state_t                  r_state, w_state;
   logic [OFFBITS-1:0]      r_req_off, w_req_off;
   logic [1:0]              r_req_len, w_req_len;
   logic [LINEWORDBITS-1:0] r_cnt, w_cnt;
   logic                    r_abort, w_abort, w_abort_now;
   logic                    r_mem_rd_req, w_mem_rd_req;
   logic [ADDRBITS-1:0]     r_mem_addr, w_mem_addr;
   logic [ADDRBITS-1:0]     r_fill_addr, w_fill_addr, w_beat_addr;
   logic [DATABITS-1:0]     r_fill_data, w_fill_data;
   logic [DATABITS-1:0]     r_resp_data, w_resp_data;
   logic                    r_fill_we, w_fill_we;
   logic                    r_fill_done, w_fill_done;
   logic                    r_resp_valid, w_resp_valid;
   logic                    r_queue_pop, w_queue_pop;
   logic                    r_busy, w_busy;

   // Critical-word extraction: byte/halfword lanes are zero-extended.
   function automatic logic [DATABITS-1:0] sel_resp(input logic [DATABITS-1:0] beat,
                                                    input logic [1:0]          len,
                                                    input logic [1:0]          lane);
      logic [DATABITS-1:0] res;
      res = beat;
      case (len)
         2'd0:    res = {{(DATABITS-8){1'b0}}, beat[{lane, 3'b000} +: 8]};
         2'd1:    res = {{(DATABITS-16){1'b0}}, beat[{lane[1], 4'b0000} +: 16]};
         default: res = beat;
      endcase
      return res;
   endfunction

   assign w_beat_addr = r_mem_addr | {{(ADDRBITS-OFFBITS){1'b0}}, r_cnt, 2'b00};

   // Next-state and next-output decode; only the low line offset of the request is kept.
   always_comb begin
      w_state      = r_state;
      w_req_off    = r_req_off;
      w_req_len    = r_req_len;
      w_cnt        = r_cnt;
      w_abort      = r_abort;
      w_abort_now  = r_abort | bus.flush;
      w_mem_rd_req = r_mem_rd_req;
      w_mem_addr   = r_mem_addr;
      w_fill_addr  = r_fill_addr;
      w_fill_data  = r_fill_data;
      w_resp_data  = r_resp_data;
      w_fill_we    = 1'b0;
      w_fill_done  = 1'b0;
      w_resp_valid = 1'b0;
      w_queue_pop  = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.queue_not_empty) begin
               w_state      = REQ;
               w_req_off    = bus.queue_out_addr[OFFBITS-1:0];
               w_req_len    = bus.queue_out_wordlen;
               w_mem_rd_req = 1'b1;
               w_mem_addr   = {bus.queue_out_addr[ADDRBITS-1:OFFBITS], {OFFBITS{1'b0}}};
            end else begin
               w_state = IDLE;
            end
         end
         REQ: begin
            w_abort = w_abort_now;
            if (bus.mem_ack) begin
               w_mem_rd_req = 1'b0;
               w_cnt        = {LINEWORDBITS{1'b0}};
               w_state      = BURST;
            end else begin
               w_state = REQ;
            end
         end
         BURST: begin
            w_abort = w_abort_now;
            if (bus.mem_rd_valid) begin
               w_cnt = r_cnt + LINEWORDBITS'(1);
               // A flush in the same cycle as a beat already suppresses that beat.
               if (!w_abort_now) begin
                  w_fill_we   = 1'b1;
                  w_fill_addr = w_beat_addr;
                  w_fill_data = bus.mem_rd_data;
                  if (r_cnt == r_req_off[OFFBITS-1:2]) begin
                     w_resp_valid = 1'b1;
                     w_resp_data  = sel_resp(bus.mem_rd_data, r_req_len, r_req_off[1:0]);
                  end else begin
                     w_resp_valid = 1'b0;
                  end
               end else begin
                  w_fill_we = 1'b0;
               end
               if (r_cnt == LINEWORDBITS'(LINEWORDS-1)) begin
                  w_state     = DONE;
                  w_queue_pop = 1'b1;
                  w_fill_done = !w_abort_now;
               end else begin
                  w_state = BURST;
               end
            end else begin
               w_state = BURST;
            end
         end
         DONE: begin
            w_state = IDLE;
            w_abort = 1'b0;
         end
         default: begin
            w_state = IDLE;
         end
      endcase
      w_busy = (w_state != IDLE);
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state;
      end
   end

   // Request context and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_req_off    <= {OFFBITS{1'b0}};
         r_req_len    <= 2'b00;
         r_cnt        <= {LINEWORDBITS{1'b0}};
         r_abort      <= 1'b0;
         r_mem_rd_req <= 1'b0;
         r_mem_addr   <= {ADDRBITS{1'b0}};
         r_fill_addr  <= {ADDRBITS{1'b0}};
         r_fill_data  <= {DATABITS{1'b0}};
         r_resp_data  <= {DATABITS{1'b0}};
         r_fill_we    <= 1'b0;
         r_fill_done  <= 1'b0;
         r_resp_valid <= 1'b0;
         r_queue_pop  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_req_off    <= w_req_off;
         r_req_len    <= w_req_len;
         r_cnt        <= w_cnt;
         r_abort      <= w_abort;
         r_mem_rd_req <= w_mem_rd_req;
         r_mem_addr   <= w_mem_addr;
         r_fill_addr  <= w_fill_addr;
         r_fill_data  <= w_fill_data;
         r_resp_data  <= w_resp_data;
         r_fill_we    <= w_fill_we;
         r_fill_done  <= w_fill_done;
         r_resp_valid <= w_resp_valid;
         r_queue_pop  <= w_queue_pop;
         r_busy       <= w_busy;
      end
   end

   assign bus.queue_pop  = r_queue_pop;
   assign bus.mem_rd_req = r_mem_rd_req;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.fill_we    = r_fill_we;
   assign bus.fill_addr  = r_fill_addr;
   assign bus.fill_data  = r_fill_data;
   assign bus.fill_done  = r_fill_done;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_data  = r_resp_data;
   assign bus.busy       = r_busy;
endmodule

// File: tb/tb_icache_fetch.sv
// Bench for icache_fetch: table of fetch requests plus hand-written stall,
// flush, back-to-back and mid-burst reset sequences, checked via scoreboards.
module tb_icache_fetch;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   icache_fetch_if #(.ADDRBITS(32), .DATABITS(32)) bus();

   icache_fetch #(.DATABITS(32), .ADDRBITS(32), .LINEWORDBITS(3)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct { logic [31:0] addr; logic [1:0] len; logic [31:0] beat5; logic [31:0] exp_resp; } vec_t;
   typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } fill_t;
   typedef struct { int cyc; logic [31:0] data; } resp_t;
   typedef struct { int cyc; logic done; } pop_t;

   fill_t fill_q[$];
   resp_t resp_q[$];
   pop_t  pop_q[$];
   vec_t  vecs[7];

   int cyc = 0;
   int n_chk = 0;
   int n_err = 0;
   int n_fill = 0;
   int n_pop = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Output monitor: every strobe must match the oldest expected entry.
   always @(negedge clk) begin
      fill_t fe;
      resp_t re;
      pop_t  pe;
      if (reset_n) begin
         if (bus.fill_we) begin
            n_fill++;
            check("fill_expected", 64'(fill_q.size() != 0), 64'd1);
            if (fill_q.size() != 0) begin
               fe = fill_q.pop_front();
               check("fill_cycle", 64'(cyc), 64'(fe.cyc));
               check("fill_addr", 64'(bus.fill_addr), 64'(fe.addr));
               check("fill_data", 64'(bus.fill_data), 64'(fe.data));
            end
         end
         if (bus.resp_valid) begin
            check("resp_expected", 64'(resp_q.size() != 0), 64'd1);
            if (resp_q.size() != 0) begin
               re = resp_q.pop_front();
               check("resp_cycle", 64'(cyc), 64'(re.cyc));
               check("resp_data", 64'(bus.resp_data), 64'(re.data));
            end
         end
         if (bus.queue_pop) begin
            n_pop++;
            check("pop_expected", 64'(pop_q.size() != 0), 64'd1);
            if (pop_q.size() != 0) begin
               pe = pop_q.pop_front();
               check("pop_cycle", 64'(cyc), 64'(pe.cyc));
               check("fill_done", 64'(bus.fill_done), 64'(pe.done));
            end
         end
         if (bus.fill_done) check("fill_done_with_pop", 64'(bus.queue_pop), 64'd1);
      end
   end

   function automatic logic any_output();
      return |{bus.queue_pop, bus.mem_rd_req, bus.mem_addr, bus.fill_we, bus.fill_addr,
               bus.fill_data, bus.fill_done, bus.resp_valid, bus.resp_data, bus.busy};
   endfunction

   // One full request: queue head, request/ack handshake, 8 beats, DONE, IDLE.
   task automatic run_req(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] beat5,
                          input logic [31:0] exp_resp, input int ack_dly, input int gap,
                          input int flush_beat, input int rst_beat, input logic nxt_v,
                          input logic [31:0] nxt_addr, input logic [1:0] nxt_len,
                          output int t_req, output int t_pop);
      logic [31:0] line;
      logic [31:0] d;
      logic        fresh;
      logic        aborted;
      int          t0;
      int          crit;
      fill_t       fe;
      resp_t       re;
      pop_t        pe;
      line    = addr & 32'hFFFF_FFE0;
      crit    = int'(addr[4:2]);
      fresh   = !bus.queue_not_empty;
      aborted = 1'b0;
      t_req   = -1;
      t_pop   = -1;
      bus.queue_out_addr    = addr;
      bus.queue_out_wordlen = len;
      bus.queue_not_empty   = 1'b1;
      t0 = cyc;
      for (int k = 0; k < 40 && !bus.mem_rd_req; k++) @(negedge clk);
      check("req_seen", 64'(bus.mem_rd_req), 64'd1);
      if (!bus.mem_rd_req) return;
      t_req = cyc;
      if (fresh) check("req_latency", 64'(t_req - t0), 64'd1);
      check("mem_addr", 64'(bus.mem_addr), 64'(line));
      for (int k = 0; k < ack_dly; k++) begin
         bus.mem_rd_valid = 1'b1;
         bus.mem_rd_data  = 32'hDEAD_0000 + 32'(k);
         @(negedge clk);
         check("req_hold", 64'({bus.mem_rd_req, bus.mem_addr}), 64'({1'b1, line}));
      end
      bus.mem_rd_valid = 1'b0;
      bus.mem_ack      = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      check("req_drop", 64'(bus.mem_rd_req), 64'd0);
      for (int i = 0; i < 8; i++) begin
         for (int g = 0; g < gap; g++) @(negedge clk);
         if (i == rst_beat) begin
            #2 reset_n = 1'b0;
            #1 check("reset_outputs_zero", 64'(any_output()), 64'd0);
            bus.queue_not_empty = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
            return;
         end
         d = (i == 5) ? beat5 : 32'h100 + 32'(i);
         bus.mem_rd_valid = 1'b1;
         bus.mem_rd_data  = d;
         if (i == flush_beat) begin
            bus.flush = 1'b1;
            aborted   = 1'b1;
         end
         if (!aborted) begin
            fe.cyc = cyc + 1; fe.addr = line + 32'(4 * i); fe.data = d;
            fill_q.push_back(fe);
            if (i == crit) begin
               re.cyc = cyc + 1; re.data = exp_resp;
               resp_q.push_back(re);
            end
         end
         if (i == 7) begin
            pe.cyc = cyc + 1; pe.done = !aborted;
            pop_q.push_back(pe);
         end
         @(negedge clk);
         bus.mem_rd_valid = 1'b0;
         bus.flush        = 1'b0;
      end
      t_pop = cyc;
      check("busy_in_done", 64'(bus.busy), 64'd1);
      bus.queue_not_empty   = nxt_v;
      bus.queue_out_addr    = nxt_addr;
      bus.queue_out_wordlen = nxt_len;
      @(negedge clk);
      check("busy_in_idle", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int tr, tp, tr2, tp2, pops0, fills0;
      vecs[0] = '{32'h0000_1234, 2'd2, 32'h0000_0105, 32'h0000_0105};
      vecs[1] = '{32'h0000_1236, 2'd1, 32'hAABB_CCDD, 32'h0000_AABB};
      vecs[2] = '{32'h0000_1237, 2'd0, 32'hAABB_CCDD, 32'h0000_00AA};
      vecs[3] = '{32'h0000_1235, 2'd0, 32'hAABB_CCDD, 32'h0000_00CC};
      vecs[4] = '{32'h0000_1234, 2'd1, 32'hAABB_CCDD, 32'h0000_CCDD};
      vecs[5] = '{32'h0000_1237, 2'd1, 32'hAABB_CCDD, 32'h0000_AABB};
      vecs[6] = '{32'h0000_1236, 2'd3, 32'hAABB_CCDD, 32'hAABB_CCDD};

      bus.queue_out_addr    = 32'h0;
      bus.queue_out_wordlen = 2'd0;
      bus.queue_not_empty   = 1'b0;
      bus.flush             = 1'b0;
      bus.mem_ack           = 1'b0;
      bus.mem_rd_valid      = 1'b0;
      bus.mem_rd_data       = 32'h0;
      repeat (2) @(negedge clk);
      check("reset_state", 64'(any_output()), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // A flush while idle must leave no trace on the next request.
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("idle_flush_busy", 64'(bus.busy), 64'd0);

      for (int v = 0; v < 7; v++)
         run_req(vecs[v].addr, vecs[v].len, vecs[v].beat5, vecs[v].exp_resp,
                 2, 0, -1, -1, 1'b0, 32'h0, 2'd0, tr, tp);

      fills0 = n_fill;
      run_req(32'h0000_3010, 2'd2, 32'h105, 32'h104, 10, 1, -1, -1, 1'b0, 32'h0, 2'd0, tr, tp);
      check("stall_fill_count", 64'(n_fill - fills0), 64'd8);

      fills0 = n_fill;
      run_req(32'h0000_0040, 2'd2, 32'h105, 32'h100, 2, 0, 2, -1, 1'b0, 32'h0, 2'd0, tr, tp);
      check("flush_fill_count", 64'(n_fill - fills0), 64'd2);

      pops0 = n_pop;
      run_req(32'h0000_1000, 2'd2, 32'h105, 32'h100, 2, 0, -1, -1, 1'b1, 32'h0000_2004, 2'd2, tr, tp);
      run_req(32'h0000_2004, 2'd2, 32'h105, 32'h101, 2, 0, -1, -1, 1'b0, 32'h0, 2'd0, tr2, tp2);
      check("b2b_req_gap", 64'(tr2 - tp), 64'd2);
      check("b2b_pops", 64'(n_pop - pops0), 64'd2);

      run_req(32'h0000_5018, 2'd2, 32'h105, 32'h106, 2, 0, -1, 4, 1'b0, 32'h0, 2'd0, tr, tp);
      check("after_reset_busy", 64'(bus.busy), 64'd0);
      run_req(32'h0000_6000, 2'd2, 32'h105, 32'h100, 2, 0, -1, -1, 1'b0, 32'h0, 2'd0, tr, tp);

      repeat (3) @(negedge clk);
      check("fill_q_drained", 64'(fill_q.size()), 64'd0);
      check("resp_q_drained", 64'(resp_q.size()), 64'd0);
      check("pop_q_drained", 64'(pop_q.size()), 64'd0);
      check("total_pops", 64'(n_pop), 64'd12);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Downstream consumer of the icache request queue.
- Takes the head request (address, word length) and issues one line-sized burst read to memory, starting at the line-aligned address.
- Writes every returned beat into the cache line storage and returns the requested instruction data (critical word) to the fetch unit.
- Retires the queue entry with a single-cycle pop when the burst completes.

Parameters:
- DATABITS, 32, memory beat / cache word width; fixed at 32 (4 bytes per word).
- ADDRBITS, 32, byte address width.
- LINEWORDBITS, 3, log2 of words per cache line.
- LINEWORDS, 2**LINEWORDBITS, words per line (8 = 32 bytes).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- queue_out_addr  in  ADDRBITS  head request byte address.
- queue_out_wordlen  in  2  head request size: 0=byte, 1=halfword, 2=word, 3=word.
- queue_not_empty  in  1  head entry valid.
- queue_pop  out  1  one-cycle pulse that retires the head entry.
- flush  in  1  abort the current request (pipeline redirect).
- mem_rd_req  out  1  burst read request.
- mem_addr  out  ADDRBITS  line base address, low LINEWORDBITS+2 bits zero.
- mem_ack  in  1  memory accepted the request.
- mem_rd_valid  in  1  read beat valid.
- mem_rd_data  in  DATABITS  read beat data.
- fill_we  out  1  cache line word write strobe.
- fill_addr  out  ADDRBITS  word-aligned byte address of the written word.
- fill_data  out  DATABITS  word being written.
- fill_done  out  1  pulse: the whole line is valid.
- resp_valid  out  1  pulse: requested data available.
- resp_data  out  DATABITS  requested data, zero-extended.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: state IDLE. All outputs, the beat counter and the abort flag are 0.
- States: IDLE, REQ, BURST, DONE.
- IDLE:
  - If queue_not_empty, latch req_addr=queue_out_addr and req_len=queue_out_wordlen, then go to REQ.
  - Decision is registered: mem_rd_req rises 1 cycle after queue_not_empty is sampled high.
- REQ:
  - mem_rd_req=1 and mem_addr={req_addr[ADDRBITS-1:LINEWORDBITS+2],0}, both held stable until mem_ack is sampled high.
  - Then mem_rd_req drops, beat counter cnt=0, go to BURST.
  - mem_rd_valid in REQ is ignored.
- BURST: each cycle with mem_rd_valid=1:
  - Registered outputs next cycle: fill_we=1, fill_addr=mem_addr+4*cnt, fill_data=mem_rd_data.
  - If cnt==req_addr[LINEWORDBITS+1:2], also registered next cycle: resp_valid=1 and resp_data selected from that beat:
    - len 0: byte lane req_addr[1:0].
    - len 1: halfword req_addr[1] (req_addr[0] ignored).
    - len 2/3: full word.
  - cnt increments and wraps modulo LINEWORDS. A beat with cnt==LINEWORDS-1 moves the FSM to DONE.
  - Gaps in mem_rd_valid are tolerated with no timeout.
- DONE (1 cycle):
  - queue_pop=1.
  - fill_done=1 unless aborted.
  - The last fill_we coincides with this cycle.
  - Return to IDLE and clear the abort flag.
- Back-to-back requests: the IDLE cycle after DONE re-samples queue_not_empty, which already reflects the pop.
- Minimum per-request overhead: 3 cycles plus memory latency.
- flush:
  - IDLE: no effect.
  - REQ or BURST: set the abort flag. The request is never retracted; the burst is drained to completion.
  - While aborted: fill_we and resp_valid are suppressed, fill_done stays 0, queue_pop is still pulsed in DONE.
  - flush in the same cycle as the critical beat suppresses that resp_valid.
- Mid-burst reset: immediately return to IDLE with outputs 0. Memory-side cleanup is outside this block's scope.
- Every pulse output is exactly one cycle wide.

Test Plan:
- Word fetch: queue addr 0x0000_1234, len 2; ack after 2 cycles; beats 0x100..0x107 back-to-back.
  - -> mem_addr 0x0000_1220.
  - -> fill_addr 0x1220..0x123C in order.
  - -> resp_valid once with resp_data 0x105, one cycle after beat 5.
  - -> fill_done and queue_pop together, one cycle after the last beat.
- Subword: addr 0x1236 len 1, beat5=0xAABBCCDD -> resp_data 0x0000AABB. addr 0x1237 len 0 -> 0x000000AA. addr 0x1235 len 0 -> 0x000000CC.
- Stalled memory: mem_ack held low for 10 cycles, then mem_rd_valid asserted every other cycle.
  - -> mem_rd_req and mem_addr stable during the stall.
  - -> exactly 8 fill_we.
  - -> no beat accepted before ack.
- Flush: flush pulse at beat 2 of a request to addr 0x40.
  - -> fill_we for beats 0-1 only, none after.
  - -> no resp_valid for word 0 index... none after the flush (critical word 0 already returned before the flush).
  - -> fill_done stays 0; queue_pop pulses once.
- Back-to-back: two queued requests, 0x1000 and 0x2004.
  - -> second mem_rd_req 2 cycles after the first queue_pop.
  - -> queue_pop pulses exactly twice.
- Reset during BURST at beat 4 -> all outputs 0 the same cycle; busy=0; the next request starts cleanly from REQ.
